ifu_fetch_unit: RTL and testbench

- Instruction fetch unit for the multi-cycle NPC core. It is the producer on the inst/pc interface that the decode stage consumes.
- Holds the architectural PC and issues one read per instruction on a simple AXI-lite-style read channel.
- Presents the fetched inst/pc to decode with a valid/ready handshake, then waits for write-back to supply the next PC.
- Exactly one instruction is in flight at a time; there is no prefetch and no cache.

---
 rtl/ifu_fetch_unit_pkg.sv | 22 ++
 rtl/ifu_fetch_unit.sv | 121 ++++++++++++
 tb/tb_ifu_fetch_unit.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/ifu_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit and the PC-reset logic in write-back.
// Holds the FSM state encoding, the AXI-lite OKAY response code and the default reset PC.
// Also holds a small alignment helper used when deciding whether a fetch may go to the bus.
package ifu_fetch_unit_pkg;

  // FSM state encoding, fixed at 2 bits so other blocks can decode it if needed.
  typedef enum logic [1:0] {
    S_AR   = 2'd0,
    S_R    = 2'd1,
    S_OUT  = 2'd2,
    S_WAIT = 2'd3
  } state_t;

  localparam logic [1:0]  RESP_OKAY        = 2'b00;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

  // Instructions are word aligned; anything else is a misaligned-PC fault.
  function automatic logic is_word_aligned(input logic [1:0] addr_lo);
    return (addr_lo == 2'b00);
  endfunction

endpackage

// File: rtl/ifu_fetch_unit.sv
// Instruction fetch unit: holds the PC, reads one instruction per handoff, presents it to decode.
// Latency: out_valid 2 cycles after entering S_AR when arready/rvalid are already high.
// Backpressure: arvalid/araddr held until arready; inst/pc_o/inst_fault held until out_ready.
//
// Ports:
//   clk, rst (async, active low)
//   araddr/arvalid/arready          : read request channel (IFU is master)
//   rdata/rresp/rvalid/rready       : read data channel
//   inst/pc_o/inst_fault/out_valid/out_ready : handoff to decode
//   npc_valid/npc                   : next PC from write-back (one-cycle pulse)
//   fetch_cnt                       : number of completed handoffs (wraps)
module ifu_fetch_unit
  import ifu_fetch_unit_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC[ADDR_W-1:0]
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [31:0]       rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready,
  output logic [31:0]       inst,
  output logic [ADDR_W-1:0] pc_o,
  output logic              inst_fault,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic              npc_valid,
  input  logic [ADDR_W-1:0] npc,
  output logic [31:0]       fetch_cnt
);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc, pc_nxt;
  logic [31:0]       inst_nxt;
  logic              fault_nxt;
  logic [31:0]       cnt_nxt;

  assign araddr = pc;
  assign pc_o   = pc;

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    inst_nxt  = inst;
    fault_nxt = inst_fault;
    cnt_nxt   = fetch_cnt;
    unique case (state)
      S_AR: begin
        // A misaligned PC never reaches the bus; it is reported as a fault directly.
        if (!is_word_aligned(pc[1:0])) begin
          inst_nxt  = '0;
          fault_nxt = 1'b1;
          state_nxt = S_OUT;
        end else if (arvalid && arready) begin
          state_nxt = S_R;
        end
      end
      S_R: begin
        if (rready && rvalid) begin
          inst_nxt  = rdata;
          fault_nxt = (rresp != RESP_OKAY);
          state_nxt = S_OUT;
        end
      end
      S_OUT: begin
        if (out_valid && out_ready) begin
          cnt_nxt   = fetch_cnt + 32'd1;
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (npc_valid) begin
          pc_nxt    = npc;
          state_nxt = S_AR;
        end
      end
    endcase
  end

  // The handshake outputs are registered copies decoded from the next state, so
  // they are low during reset and have no combinational path from any input.
  // arvalid rises in the first cycle after reset release because the reset state
  // is S_AR while the registered arvalid is still 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_AR;
      pc         <= RESET_PC;
      inst       <= '0;
      inst_fault <= 1'b0;
      fetch_cnt  <= '0;
      arvalid    <= 1'b0;
      rready     <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      inst       <= inst_nxt;
      inst_fault <= fault_nxt;
      fetch_cnt  <= cnt_nxt;
      arvalid    <= (state_nxt == S_AR) && is_word_aligned(pc_nxt[1:0]);
      rready     <= (state_nxt == S_R);
      out_valid  <= (state_nxt == S_OUT);
    end
  end

`ifndef SYNTHESIS
  // A next-PC pulse outside S_WAIT is dropped; flag it so the producer can be found.
  always @(posedge clk) begin
    if (rst) begin
      assert (!(npc_valid && (state != S_WAIT)))
        else $warning("ifu_fetch_unit: npc_valid ignored outside S_WAIT (npc=%h pc=%h)", npc, pc);
    end
  end
`endif

endmodule

// File: tb/tb_ifu_fetch_unit.sv
// Self-checking bench for ifu_fetch_unit.
// Per-cycle vector table for the basic, bus-error and misaligned flows, then
// hand-written sequences for backpressure and asynchronous reset.
module tb_ifu_fetch_unit;

  logic        clk;
  logic        rst;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] inst;
  logic [31:0] pc_o;
  logic        inst_fault;
  logic        out_valid;
  logic        out_ready;
  logic        npc_valid;
  logic [31:0] npc;
  logic [31:0] fetch_cnt;

  ifu_fetch_unit #(
    .ADDR_W   (32),
    .RESET_PC (32'h8000_0000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .araddr     (araddr),
    .arvalid    (arvalid),
    .arready    (arready),
    .rdata      (rdata),
    .rresp      (rresp),
    .rvalid     (rvalid),
    .rready     (rready),
    .inst       (inst),
    .pc_o       (pc_o),
    .inst_fault (inst_fault),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .npc_valid  (npc_valid),
    .npc        (npc),
    .fetch_cnt  (fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Advance one clock and settle past the edge before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Inputs applied for one cycle, then outputs expected right after the next edge.
  // e_hs = {arvalid, rready, out_valid, inst_fault}; araddr and pc_o both expect e_pc.
  typedef struct {
    logic        arready;
    logic        rvalid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        out_ready;
    logic        npc_valid;
    logic [31:0] npc;
    logic [3:0]  e_hs;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t tbl[15];

  initial begin
    // Fetch 1 at reset PC, zero-wait everywhere.
    tbl[0]  = '{1'b1, 1'b1, 32'h0010_0093, 2'b00, 1'b1, 1'b0, 32'h0, 4'b1000, 32'h8000_0000, 32'h0,         32'd0};
    tbl[1]  = '{1'b1, 1'b1, 32'h0010_0093, 2'b00, 1'b1, 1'b0, 32'h0, 4'b0100, 32'h8000_0000, 32'h0,         32'd0};
    tbl[2]  = '{1'b1, 1'b1, 32'h0010_0093, 2'b00, 1'b1, 1'b0, 32'h0, 4'b0010, 32'h8000_0000, 32'h0010_0093, 32'd0};
    tbl[3]  = '{1'b1, 1'b1, 32'h0010_0093, 2'b00, 1'b1, 1'b0, 32'h0, 4'b0000, 32'h8000_0000, 32'h0010_0093, 32'd1};
    // Fetch 2 at 80000010 returns a bus error.
    tbl[4]  = '{1'b1, 1'b1, 32'hDEAD_BEEF, 2'b10, 1'b1, 1'b1, 32'h8000_0010, 4'b1000, 32'h8000_0010, 32'h0010_0093, 32'd1};
    tbl[5]  = '{1'b1, 1'b1, 32'hDEAD_BEEF, 2'b10, 1'b1, 1'b0, 32'h0,         4'b0100, 32'h8000_0010, 32'h0010_0093, 32'd1};
    tbl[6]  = '{1'b1, 1'b1, 32'hDEAD_BEEF, 2'b10, 1'b1, 1'b0, 32'h0,         4'b0011, 32'h8000_0010, 32'hDEAD_BEEF, 32'd1};
    tbl[7]  = '{1'b1, 1'b1, 32'hDEAD_BEEF, 2'b10, 1'b1, 1'b0, 32'h0,         4'b0001, 32'h8000_0010, 32'hDEAD_BEEF, 32'd2};
    // Fetch 3 at 80000004 is clean; a stray npc_valid during the handoff is ignored.
    tbl[8]  = '{1'b1, 1'b1, 32'h0000_0013, 2'b00, 1'b1, 1'b1, 32'h8000_0004, 4'b1001, 32'h8000_0004, 32'hDEAD_BEEF, 32'd2};
    tbl[9]  = '{1'b1, 1'b1, 32'h0000_0013, 2'b00, 1'b1, 1'b0, 32'h0,         4'b0101, 32'h8000_0004, 32'hDEAD_BEEF, 32'd2};
    tbl[10] = '{1'b1, 1'b1, 32'h0000_0013, 2'b00, 1'b1, 1'b0, 32'h0,         4'b0010, 32'h8000_0004, 32'h0000_0013, 32'd2};
    tbl[11] = '{1'b1, 1'b1, 32'h0000_0013, 2'b00, 1'b1, 1'b1, 32'h1234_5678, 4'b0000, 32'h8000_0004, 32'h0000_0013, 32'd3};
    // Fetch 4 at misaligned 80000006: no bus request, fault reported with inst=0.
    tbl[12] = '{1'b1, 1'b1, 32'h0000_0013, 2'b00, 1'b1, 1'b1, 32'h8000_0006, 4'b0000, 32'h8000_0006, 32'h0000_0013, 32'd3};
    tbl[13] = '{1'b1, 1'b1, 32'h0000_0013, 2'b00, 1'b1, 1'b0, 32'h0,         4'b0011, 32'h8000_0006, 32'h0,         32'd3};
    tbl[14] = '{1'b1, 1'b1, 32'h0000_0013, 2'b00, 1'b1, 1'b0, 32'h0,         4'b0001, 32'h8000_0006, 32'h0,         32'd4};

    rst       = 1'b0;
    arready   = 1'b1;
    rvalid    = 1'b1;
    rdata     = 32'h0010_0093;
    rresp     = 2'b00;
    out_ready = 1'b1;
    npc_valid = 1'b0;
    npc       = 32'h0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset hs", {28'h0, arvalid, rready, out_valid, inst_fault}, 32'h0);
    chk("reset pc_o", pc_o, 32'h8000_0000);
    chk("reset araddr", araddr, 32'h8000_0000);
    chk("reset inst", inst, 32'h0);
    chk("reset fetch_cnt", fetch_cnt, 32'h0);
    rst = 1'b1;

    for (int i = 0; i < 15; i++) begin
      arready   = tbl[i].arready;
      rvalid    = tbl[i].rvalid;
      rdata     = tbl[i].rdata;
      rresp     = tbl[i].rresp;
      out_ready = tbl[i].out_ready;
      npc_valid = tbl[i].npc_valid;
      npc       = tbl[i].npc;
      step();
      chk($sformatf("vec%0d hs", i), {28'h0, arvalid, rready, out_valid, inst_fault}, {28'h0, tbl[i].e_hs});
      chk($sformatf("vec%0d araddr", i), araddr, tbl[i].e_pc);
      chk($sformatf("vec%0d pc_o", i), pc_o, tbl[i].e_pc);
      chk($sformatf("vec%0d inst", i), inst, tbl[i].e_inst);
      chk($sformatf("vec%0d fetch_cnt", i), fetch_cnt, tbl[i].e_cnt);
    end

    // Request and output backpressure, delayed read data, stray npc_valid in S_OUT.
    arready   = 1'b0;
    rvalid    = 1'b0;
    out_ready = 1'b0;
    npc_valid = 1'b1;
    npc       = 32'h8000_0020;
    step();
    npc_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("ar_bp%0d arvalid", i), {31'h0, arvalid}, 32'd1);
      chk($sformatf("ar_bp%0d araddr", i), araddr, 32'h8000_0020);
      chk($sformatf("ar_bp%0d rready", i), {31'h0, rready}, 32'd0);
      step();
    end
    // Still waiting: the third low-arready edge must not have moved to S_R.
    chk("ar_bp hold arvalid", {31'h0, arvalid}, 32'd1);
    arready = 1'b1;
    step();
    arready = 1'b0;
    chk("ar_acc rready", {31'h0, rready}, 32'd1);
    chk("ar_acc arvalid", {31'h0, arvalid}, 32'd0);
    step();
    chk("r_dly rready", {31'h0, rready}, 32'd1);
    chk("r_dly out_valid", {31'h0, out_valid}, 32'd0);
    rvalid = 1'b1;
    rdata  = 32'hCAFE_0001;
    step();
    rvalid = 1'b0;
    rdata  = 32'h0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("out_bp%0d out_valid", i), {31'h0, out_valid}, 32'd1);
      chk($sformatf("out_bp%0d inst", i), inst, 32'hCAFE_0001);
      chk($sformatf("out_bp%0d pc_o", i), pc_o, 32'h8000_0020);
      chk($sformatf("out_bp%0d fetch_cnt", i), fetch_cnt, 32'd4);
      npc_valid = (i == 2);
      npc       = 32'h0000_0100;
      step();
    end
    npc_valid = 1'b0;
    chk("stray npc pc_o", pc_o, 32'h8000_0020);
    chk("stray npc out_valid", {31'h0, out_valid}, 32'd1);
    out_ready = 1'b1;
    step();
    chk("out_acc out_valid", {31'h0, out_valid}, 32'd0);
    chk("out_acc fetch_cnt", fetch_cnt, 32'd5);
    step();
    chk("out_acc once fetch_cnt", fetch_cnt, 32'd5);

    // Asynchronous reset while in S_R.
    arready   = 1'b1;
    npc_valid = 1'b1;
    npc       = 32'h8000_0030;
    step();
    npc_valid = 1'b0;
    chk("pre_rst araddr", araddr, 32'h8000_0030);
    step();
    chk("pre_rst rready", {31'h0, rready}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst hs", {28'h0, arvalid, rready, out_valid, inst_fault}, 32'h0);
    chk("async_rst pc_o", pc_o, 32'h8000_0000);
    chk("async_rst inst", inst, 32'h0);
    chk("async_rst fetch_cnt", fetch_cnt, 32'h0);
    step();
    rst       = 1'b1;
    rvalid    = 1'b1;
    rdata     = 32'h0050_0113;
    out_ready = 1'b1;
    step();
    chk("restart arvalid", {31'h0, arvalid}, 32'd1);
    chk("restart araddr", araddr, 32'h8000_0000);
    step();
    chk("restart rready", {31'h0, rready}, 32'd1);
    step();
    chk("restart out_valid", {31'h0, out_valid}, 32'd1);
    chk("restart inst", inst, 32'h0050_0113);
    chk("restart pc_o", pc_o, 32'h8000_0000);
    step();
    chk("restart fetch_cnt", fetch_cnt, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
